// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops 64-bit words from an upstream FIFO and sends each one
// downstream as four 16-bit lanes, lane 0 (bits 15:0) first. While a word is
// held, the next one is popped in the same cycle its last lane is accepted,
// so words follow each other with no idle cycle between them.
module fifo_unpacker (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [63:0] data_in,
    output logic        pop_fifo,
    input  logic        flush,
    output logic [15:0] data_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [1:0]  beat
);

    typedef enum logic {
        ST_EMPTY = 1'b0,  // no word held
        ST_SEND  = 1'b1   // word held in r_word, lane r_cnt on the output
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_nxt;
    logic [63:0] r_word;
    logic [63:0] w_word_nxt;
    logic        w_accept;
    logic        w_pop;

    assign out_valid = (r_state == ST_SEND);
    assign w_accept  = out_valid & out_ready;
    assign beat      = r_cnt;
    assign out_last  = out_valid & (r_cnt == 2'd3);
    // Lane select: {r_cnt, 4'b0} is r_cnt*16, widened so the offset cannot overflow.
    assign data_out  = r_word[{r_cnt, 4'b0000} +: 16];
    // No pop may reach the FIFO controller while reset is held.
    assign pop_fifo  = w_pop & ~rst;

    // Next-state, next lane counter, next held word and the pop request.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the branches below can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_word_nxt  = r_word;
        w_pop       = 1'b0;

        if (flush) begin
            // Discard the held word. A lane accepted this same cycle has
            // still been delivered, so nothing has to be replayed.
            w_state_nxt = ST_EMPTY;
            w_cnt_nxt   = 2'd0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (!fifo_empty) begin
                        w_pop       = 1'b1;
                        w_word_nxt  = data_in;
                        w_cnt_nxt   = 2'd0;
                        w_state_nxt = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_cnt != 2'd3) begin
                            w_cnt_nxt = r_cnt + 2'd1;
                        end else if (!fifo_empty) begin
                            // Last lane leaves while the next word is
                            // loaded, so there is no bubble between words.
                            w_pop      = 1'b1;
                            w_word_nxt = data_in;
                            w_cnt_nxt  = 2'd0;
                        end else begin
                            w_cnt_nxt   = 2'd0;
                            w_state_nxt = ST_EMPTY;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    // State, lane counter and held word registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // The held word is cleared as well, so data_out reads zero during
            // reset instead of showing a stale lane.
            r_state <= ST_EMPTY;
            r_cnt   <= 2'd0;
            r_word  <= 64'd0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // the values sampled before this edge regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_word  <= w_word_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb_fifo_unpacker: directed scenarios plus randomized traffic. The upstream
// FIFO is a queue of words. The expected output stream is a queue of pending
// lanes: a pop appends the four lanes of the head word, an accept removes the
// front lane, and a flush or reset empties the queue.
module tb_fifo_unpacker;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [63:0] data_in;
    logic        pop_fifo;
    logic        flush;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [1:0]  beat;

    fifo_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .data_in    (data_in),
        .pop_fifo   (pop_fifo),
        .flush      (flush),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .beat       (beat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] fifo_q[$];   // upstream FIFO contents, head at index 0
    logic [15:0] lane_q[$];   // lanes still owed downstream, in order

    // Values seen in the most recent step, for the directed checks.
    logic        obs_valid;
    logic        obs_pop;
    logic        obs_last;
    logic [15:0] obs_data;
    logic [1:0]  obs_beat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle. Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit rdy, input bit fl);
        bit          exp_valid;
        bit          acc;
        bit          exp_pop;
        logic [63:0] w;
        out_ready  = rdy;
        flush      = fl;
        fifo_empty = (fifo_q.size() == 0);
        data_in    = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom};
        #1;
        exp_valid = (lane_q.size() != 0);
        acc       = exp_valid && rdy;
        exp_pop   = !fl && (fifo_q.size() != 0) &&
                    ((lane_q.size() == 0) || ((lane_q.size() == 1) && acc));
        obs_valid = out_valid;
        obs_pop   = pop_fifo;
        obs_last  = out_last;
        obs_data  = data_out;
        obs_beat  = beat;
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
        check("pop_fifo",  {63'd0, pop_fifo},  {63'd0, exp_pop});
        check("beat",      {62'd0, beat},
              exp_valid ? 64'(4 - lane_q.size()) : 64'd0);
        check("out_last",  {63'd0, out_last},  {63'd0, (lane_q.size() == 1)});
        if (exp_valid)
            check("data_out", {48'd0, data_out}, {48'd0, lane_q[0]});
        if (fl) begin
            lane_q.delete();
        end else begin
            if (acc) void'(lane_q.pop_front());
            if (exp_pop) begin
                w = fifo_q.pop_front();
                for (int i = 0; i < 4; i++) lane_q.push_back(w[16*i +: 16]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    endtask

    // Checks every output against its reset value while rst is high.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_last"},  {63'd0, out_last},  64'd0);
        check({tag, "_pop"},   {63'd0, pop_fifo},  64'd0);
        check({tag, "_beat"},  {62'd0, beat},      64'd0);
        check({tag, "_data"},  {48'd0, data_out},  64'd0);
    endtask

    initial begin
        int n_valid;
        rst        = 1'b1;
        fifo_empty = 1'b1;
        data_in    = 64'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, lanes LSB first, then back to empty.
        drain();
        fifo_q.push_back(64'h4444_3333_2222_1111);
        step(1'b1, 1'b0);
        check("single_pop", {63'd0, obs_pop}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            check("single_lane", {48'd0, obs_data}, 64'(16'h1111 * (i + 1)));
            check("single_last", {63'd0, obs_last}, (i == 3) ? 64'd1 : 64'd0);
        end
        step(1'b1, 1'b0);
        check("single_idle", {63'd0, obs_valid}, 64'd0);

        // Back-to-back words: eight consecutive valid lanes.
        drain();
        fifo_q.push_back({$urandom, $urandom});
        fifo_q.push_back({$urandom, $urandom});
        step(1'b1, 1'b0);
        n_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (obs_valid) n_valid++;
            if (i == 3) check("b2b_second_pop", {63'd0, obs_pop}, 64'd1);
        end
        check("b2b_valid_count", 64'(n_valid), 64'd8);

        // Backpressure at beat 2, with another word waiting upstream.
        drain();
        fifo_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
        fifo_q.push_back({$urandom, $urandom});
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("bp_data", {48'd0, obs_data}, 64'hCCCC);
            check("bp_beat", {62'd0, obs_beat}, 64'd2);
        end
        step(1'b1, 1'b0);
        check("bp_resume", {48'd0, obs_data}, 64'hCCCC);

        // Flush at beat 1 with the FIFO non-empty.
        drain();
        fifo_q.push_back({$urandom, $urandom});
        fifo_q.push_back(64'h8888_7777_6666_5555);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("flush_beat", {62'd0, obs_beat}, 64'd1);
        step(1'b1, 1'b0);
        check("flush_idle_valid", {63'd0, obs_valid}, 64'd0);
        check("flush_next_pop", {63'd0, obs_pop}, 64'd1);
        step(1'b1, 1'b0);
        check("flush_new_lane0", {48'd0, obs_data}, 64'h5555);

        // Asynchronous reset between edges, mid-word.
        drain();
        fifo_q.push_back({$urandom, $urandom});
        fifo_q.push_back(64'h0D0D_0C0C_0B0B_0A0A);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        lane_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0);
        check("post_reset_pop", {63'd0, obs_pop}, 64'd1);
        step(1'b1, 1'b0);
        check("post_reset_lane0", {48'd0, obs_data}, 64'h0A0A);
        check("post_reset_beat", {62'd0, obs_beat}, 64'd0);

        // Empty FIFO throughout, random ready and flush.
        drain();
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (fifo_q.size() < 6 && $urandom_range(0, 99) < 40)
                fifo_q.push_back({$urandom, $urandom});
            step(($urandom_range(0, 99) < 70), ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
